// File: rtl/apb_vec_acc.sv
// APB vector accelerator: operand buffers A/B, result buffer R, byte-lane add/sub/mul and dot-product.
// One word per cycle under a small IDLE/RUN/FIN sequencer; sticky DONE/ERR and a registered interrupt.
module apb_vec_acc #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int DEPTH          = 64
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      irq_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] RGN_REG = 2'd0;
    localparam logic [1:0] RGN_A   = 2'd1;
    localparam logic [1:0] RGN_B   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    typedef enum logic [1:0] {
        MODE_ADD,
        MODE_SUB,
        MODE_MUL,
        MODE_DOT
    } mode_t;

    state_t            state;
    mode_t             mode;
    logic              irq_en;
    logic              done;
    logic              err;
    logic [8:0]        len;
    logic [31:0]       acc;
    logic [IDX_W-1:0]  idx;

    logic [31:0] a_mem [DEPTH];
    logic [31:0] b_mem [DEPTH];
    logic [31:0] r_mem [DEPTH];

    // Address decode: PADDR[11:10] picks registers or one of the three buffers.
    logic [11:0]      addr;
    logic [1:0]       region;
    logic [7:0]       buf_index;
    logic [IDX_W-1:0] buf_idx;
    logic             in_range;
    logic             access;
    logic             wr_acc;
    logic             rd_acc;
    logic             is_buf;
    logic             sel_ctrl;
    logic             sel_status;
    logic             sel_len;
    logic             sel_acc;
    logic             busy;
    logic             unused_ok;

    assign addr       = PADDR[11:0];
    assign region     = addr[11:10];
    assign buf_index  = addr[9:2];
    assign buf_idx    = buf_index[IDX_W-1:0];
    assign in_range   = {1'b0, buf_index} < 9'(DEPTH);
    assign access     = PSEL & PENABLE;
    assign wr_acc     = access & PWRITE;
    assign rd_acc     = access & ~PWRITE;
    assign is_buf     = (region != RGN_REG);
    assign sel_ctrl   = !is_buf && (buf_index == 8'd0);
    assign sel_status = !is_buf && (buf_index == 8'd1);
    assign sel_len    = !is_buf && (buf_index == 8'd2);
    assign sel_acc    = !is_buf && (buf_index == 8'd3);
    assign busy       = (state != ST_IDLE);
    assign unused_ok  = &{1'b0, PADDR};

    assign PREADY = 1'b1;

    // Buffers are locked while the engine runs; only STATUS/ACC stay reachable.
    assign PSLVERR = access && ((is_buf && (!in_range || busy)) ||
                                (PWRITE && busy && (sel_ctrl || sel_len)));

    always_comb begin
        PRDATA = '0;
        if (rd_acc && !PSLVERR) begin
            if (is_buf) begin
                case (region)
                    RGN_A:   PRDATA = a_mem[buf_idx];
                    RGN_B:   PRDATA = b_mem[buf_idx];
                    default: PRDATA = r_mem[buf_idx];
                endcase
            end else if (sel_ctrl) begin
                PRDATA = {28'd0, irq_en, mode, 1'b0};
            end else if (sel_status) begin
                PRDATA = {29'd0, err, done, busy};
            end else if (sel_len) begin
                PRDATA = {23'd0, len};
            end else if (sel_acc) begin
                PRDATA = acc;
            end
        end
    end

    // Datapath: four unsigned byte lanes of the current word.
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] lane_res;
    logic [31:0] dot_sum;
    logic [15:0] prod;

    assign op_a = a_mem[idx];
    assign op_b = b_mem[idx];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        lane_res = '0;
        dot_sum  = '0;
        prod     = '0;
        for (int k = 0; k < 4; k++) begin
            prod = 16'(op_a[8*k +: 8]) * 16'(op_b[8*k +: 8]);
            case (mode)
                MODE_ADD: lane_res[8*k +: 8] = op_a[8*k +: 8] + op_b[8*k +: 8];
                MODE_SUB: lane_res[8*k +: 8] = op_a[8*k +: 8] - op_b[8*k +: 8];
                MODE_MUL: lane_res[8*k +: 8] = prod[7:0];
                default:  lane_res[8*k +: 8] = 8'd0;
            endcase
            dot_sum = dot_sum + 32'(prod);
        end
    end

    logic len_ok;
    logic last_word;
    logic start_req;

    assign len_ok    = (len != 9'd0) && (len <= 9'(DEPTH));
    assign last_word = (9'(idx) == len - 9'd1);
    assign start_req = wr_acc && sel_ctrl && !busy && PWDATA[0];

    // NOTE: buffer storage has no reset branch; clearing RAM on reset is neither needed nor mappable to SRAM.
    always_ff @(posedge HCLK) begin
        if (wr_acc && is_buf && in_range && !busy) begin
            case (region)
                RGN_A:   a_mem[buf_idx] <= PWDATA;
                RGN_B:   b_mem[buf_idx] <= PWDATA;
                default: r_mem[buf_idx] <= PWDATA;
            endcase
        end
        if (state == ST_RUN && mode != MODE_DOT) begin
            r_mem[idx] <= lane_res;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; later statements win, so FIN's DONE set beats W1C.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state  <= ST_IDLE;
            mode   <= MODE_ADD;
            irq_en <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            len    <= '0;
            acc    <= '0;
            idx    <= '0;
            irq_o  <= 1'b0;
        end else begin
            irq_o <= done & irq_en;

            if (wr_acc && sel_ctrl && !busy) begin
                mode   <= mode_t'(PWDATA[2:1]);
                irq_en <= PWDATA[3];
            end
            if (wr_acc && sel_len && !busy) begin
                len <= PWDATA[8:0];
            end
            if (wr_acc && sel_status) begin
                if (PWDATA[1]) done <= 1'b0;
                if (PWDATA[2]) err  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        if (len_ok) begin
                            idx   <= '0;
                            acc   <= '0;
                            err   <= 1'b0;
                            done  <= 1'b0;
                            state <= ST_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (mode == MODE_DOT) begin
                        acc <= acc + dot_sum;
                    end
                    if (last_word) begin
                        state <= ST_FIN;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_vec_acc.sv
// Directed bench for apb_vec_acc: APB register/buffer accesses, run timing, lane arithmetic,
// busy protection, error paths and reset in the middle of a run.
module tb_apb_vec_acc;

    localparam int DEPTH = 64;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        irq_o;

    int n_cmp = 0;
    int n_err = 0;

    apb_vec_acc #(.APB_ADDR_WIDTH(12), .DEPTH(DEPTH)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .irq_o   (irq_o)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Setup on a falling edge, access on the next; outputs sampled 1ns into the access phase.
    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic slverr);
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1;
        rdata = PRDATA;
        slverr = PSLVERR;
        @(posedge HCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data, output logic slverr);
        logic [31:0] dummy;
        apb_xfer(1'b1, addr, data, dummy, slverr);
    endtask

    task automatic rd(input logic [11:0] addr, output logic [31:0] data, output logic slverr);
        apb_xfer(1'b0, addr, 32'd0, data, slverr);
    endtask

    // Holds a STATUS read in access phase and counts cycles with BUSY set (bounded).
    task automatic count_busy(output int n, output logic [31:0] last);
        n = 0;
        last = '0;
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 12'h004;
        for (int i = 0; i < 2000; i++) begin
            #1;
            last = PRDATA;
            if (!last[0]) break;
            n++;
            @(negedge HCLK);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    logic [31:0] rdata;
    logic        serr;
    int          nbusy;
    logic [31:0] st;

    initial begin
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        // Reset state
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_pready", 32'(PREADY), 32'd1);
        rd(12'h000, rdata, serr); check("rst_ctrl", rdata, 32'd0); check("rst_ctrl_err", 32'(serr), 32'd0);
        rd(12'h004, rdata, serr); check("rst_status", rdata, 32'd0);
        rd(12'h008, rdata, serr); check("rst_len", rdata, 32'd0);
        rd(12'h00C, rdata, serr); check("rst_acc", rdata, 32'd0);

        // Add, LEN=2
        wr(12'h400, 32'h01FF7F10, serr);
        wr(12'h404, 32'h00000001, serr);
        wr(12'h800, 32'h01010101, serr);
        wr(12'h804, 32'h000000FF, serr);
        wr(12'h008, 32'd2, serr);
        rd(12'h400, rdata, serr); check("a0_readback", rdata, 32'h01FF7F10);
        wr(12'h000, 32'h1, serr); check("start_add_err", 32'(serr), 32'd0);
        count_busy(nbusy, st);
        check("add_busy_cycles", 32'(nbusy), 32'd3);
        check("add_status_done", st, 32'h2);
        rd(12'hC00, rdata, serr); check("add_r0", rdata, 32'h02008011);
        rd(12'hC04, rdata, serr); check("add_r1", rdata, 32'h00000000);

        // Dot product, LEN=1, IRQ_EN=1: 4 lanes * 2*3 = 24
        wr(12'h400, 32'h02020202, serr);
        wr(12'h800, 32'h03030303, serr);
        wr(12'h008, 32'd1, serr);
        wr(12'h000, 32'hF, serr);
        count_busy(nbusy, st);
        check("dot_busy_cycles", 32'(nbusy), 32'd2);
        rd(12'h00C, rdata, serr); check("dot_acc", rdata, 32'd24);
        check("dot_irq_set", 32'(irq_o), 32'd1);
        rd(12'hC00, rdata, serr); check("dot_r0_untouched", rdata, 32'h02008011);
        rd(12'h000, rdata, serr); check("dot_ctrl_read", rdata, 32'h0000000E);
        wr(12'h004, 32'h2, serr);
        check("w1c_irq_lag", 32'(irq_o), 32'd1);
        @(posedge HCLK); #1;
        check("w1c_irq_clear", 32'(irq_o), 32'd0);
        rd(12'h004, rdata, serr); check("w1c_status", rdata, 32'd0);

        // Busy protection, LEN=DEPTH, MODE add
        wr(12'h008, 32'(DEPTH), serr);
        wr(12'h000, 32'h1, serr);
        wr(12'h400, 32'hDEADBEEF, serr); check("busy_wr_a_err", 32'(serr), 32'd1);
        wr(12'h000, 32'h1, serr); check("busy_start_err", 32'(serr), 32'd1);
        rd(12'h400, rdata, serr); check("busy_rd_a_err", 32'(serr), 32'd1); check("busy_rd_a_data", rdata, 32'd0);
        rd(12'h00C, rdata, serr); check("busy_rd_acc_ok", 32'(serr), 32'd0);
        // Four accesses after START consumed 8 of the DEPTH+1 busy cycles.
        count_busy(nbusy, st);
        check("busy_remaining_cycles", 32'(nbusy), 32'(DEPTH + 1 - 8));
        check("busy_done", st, 32'h2);
        rd(12'h400, rdata, serr); check("busy_a0_unchanged", rdata, 32'h02020202);

        // Error paths
        wr(12'h008, 32'd0, serr);
        wr(12'h000, 32'h1, serr);
        rd(12'h004, rdata, serr); check("len0_status", rdata, 32'h6);
        wr(12'h004, 32'h4, serr);
        rd(12'h004, rdata, serr); check("err_w1c", rdata, 32'h2);
        wr(12'h008, 32'hFFFFFFFF, serr);
        rd(12'h008, rdata, serr); check("len_mask", rdata, 32'h1FF);
        wr(12'h000, 32'h1, serr);
        rd(12'h004, rdata, serr); check("len_big_status", rdata, 32'h6);
        wr(12'h008, 32'(DEPTH + 1), serr);
        wr(12'h004, 32'h4, serr);
        wr(12'h000, 32'h1, serr);
        rd(12'h004, rdata, serr); check("len_depth1_status", rdata, 32'h6);
        rd(12'(32'h400 + 4 * DEPTH), rdata, serr);
        check("oob_err", 32'(serr), 32'd1); check("oob_data", rdata, 32'd0);
        rd(12'h010, rdata, serr); check("unmapped_rd_data", rdata, 32'd0); check("unmapped_rd_err", 32'(serr), 32'd0);
        wr(12'h010, 32'h12345678, serr); check("unmapped_wr_err", 32'(serr), 32'd0);

        // Reset in the middle of a MODE 01 run
        wr(12'h008, 32'(DEPTH), serr);
        wr(12'h000, 32'h3, serr);
        repeat (5) @(negedge HCLK);
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        rd(12'h004, rdata, serr); check("midrun_rst_status", rdata, 32'd0);
        rd(12'h008, rdata, serr); check("midrun_rst_len", rdata, 32'd0);
        rd(12'h000, rdata, serr); check("midrun_rst_ctrl", rdata, 32'd0);

        // Sub, LEN=1: lanes 05-10, 80-03, 10-20, 00-01
        wr(12'h400, 32'h00108005, serr);
        wr(12'h800, 32'h01200310, serr);
        wr(12'h008, 32'd1, serr);
        wr(12'h000, 32'h3, serr);
        count_busy(nbusy, st);
        check("sub_busy_cycles", 32'(nbusy), 32'd2);
        rd(12'hC00, rdata, serr); check("sub_r0", rdata, 32'hFFF07DF5);

        // Mul, LEN=1: 04*06, 03*05, FF*FF, 10*10 (low byte each)
        wr(12'h400, 32'h10FF0304, serr);
        wr(12'h800, 32'h10FF0506, serr);
        wr(12'h000, 32'h5, serr);
        count_busy(nbusy, st);
        check("mul_busy_cycles", 32'(nbusy), 32'd2);
        rd(12'hC00, rdata, serr); check("mul_r0", rdata, 32'h00010F18);
        check("mul_irq_off", 32'(irq_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
